// File: rtl/audio_serial_frame_counter_if.sv
// Strobe inputs and registered status outputs of the audio serial frame counter.
// The counter itself uses the slave modport; whatever drives the strobes uses master.
interface audio_serial_frame_counter_if;
    logic       enable;
    logic       bit_clk_rising_edge;
    logic       bit_clk_falling_edge;
    logic       left_right_clk_rising_edge;
    logic       left_right_clk_falling_edge;
    logic       clear_error;
    logic       counting;
    logic [4:0] bit_index;
    logic [2:0] slot_index;
    logic       word_done;
    logic       frame_done;
    logic       sync_error;
    logic       error_flag;

    modport slave (
        input  enable, bit_clk_rising_edge, bit_clk_falling_edge,
        input  left_right_clk_rising_edge, left_right_clk_falling_edge, clear_error,
        output counting, bit_index, slot_index, word_done, frame_done, sync_error, error_flag
    );

    modport master (
        output enable, bit_clk_rising_edge, bit_clk_falling_edge,
        output left_right_clk_rising_edge, left_right_clk_falling_edge, clear_error,
        input  counting, bit_index, slot_index, word_done, frame_done, sync_error, error_flag
    );
endinterface

// File: rtl/audio_serial_frame_counter.sv
// Tracks bit and slot position inside I2S / left-justified / TDM audio frames
// from pre-detected bit-clock and LR-clock edge strobes.
module audio_serial_frame_counter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned JUSTIFY    = 0,
    parameter int unsigned TDM        = 0
) (
    input logic                          clk,
    input logic                          reset_n,
    audio_serial_frame_counter_if.slave  bus
);

    localparam int unsigned BIT_W  = 5;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned PAD_W  = 6;

    localparam logic [BIT_W-1:0]  BIT_TOP   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [PAD_W-1:0]  PAD_LAST  =
        PAD_W'((SLOT_BITS > DATA_WIDTH) ? (SLOT_BITS - DATA_WIDTH - 1) : 0);
    localparam bit IS_TDM   = (TDM != 0);
    localparam bit IS_LJ    = (JUSTIFY != 0);
    localparam bit PAD_FREE = (SLOT_BITS == DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        DATA  = 2'd2,
        PAD   = 2'd3
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic [BIT_W-1:0]    r_bit_index,  w_bit_nxt;
    logic [SLOT_W-1:0]   r_slot_index, w_slot_nxt;
    logic [PAD_W-1:0]    r_pad_count,  w_pad_nxt;
    logic                r_counting,   w_counting_nxt;
    logic                r_word_done,  w_word_done_nxt;
    logic                r_frame_done, w_frame_done_nxt;
    logic                r_sync_error, w_sync_error_nxt;
    logic                r_error_flag, w_error_flag_nxt;
    logic                w_sync;
    logic                w_unused_rise;

    // Rising bit-clock edges never move the counter.
    assign w_unused_rise = bus.bit_clk_rising_edge;

    assign w_sync = IS_TDM ? bus.left_right_clk_rising_edge
                           : (bus.left_right_clk_rising_edge | bus.left_right_clk_falling_edge);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_bit_index  <= '0;
            r_slot_index <= '0;
            r_pad_count  <= '0;
            r_counting   <= 1'b0;
            r_word_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_error <= 1'b0;
            r_error_flag <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_index  <= w_bit_nxt;
            r_slot_index <= w_slot_nxt;
            r_pad_count  <= w_pad_nxt;
            r_counting   <= w_counting_nxt;
            r_word_done  <= w_word_done_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sync_error <= w_sync_error_nxt;
            r_error_flag <= w_error_flag_nxt;
        end
    end

    // Sync outranks the bit clock, so a coincident falling edge is dropped.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_nxt        = r_bit_index;
        w_slot_nxt       = r_slot_index;
        w_pad_nxt        = r_pad_count;
        w_counting_nxt   = r_counting;
        w_word_done_nxt  = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_sync_error_nxt = 1'b0;
        w_error_flag_nxt = r_error_flag;

        if (!bus.enable) begin
            w_state_nxt    = IDLE;
            w_counting_nxt = 1'b0;
        end else begin
            if (w_sync) begin
                w_sync_error_nxt = (r_state != IDLE);
                w_slot_nxt       = (IS_TDM || !bus.left_right_clk_rising_edge) ? '0 : SLOT_W'(1);
                w_pad_nxt        = '0;
                if (IS_LJ) begin
                    w_state_nxt    = DATA;
                    w_counting_nxt = 1'b1;
                    w_bit_nxt      = BIT_TOP;
                end else begin
                    w_state_nxt    = DELAY;
                    w_counting_nxt = 1'b0;
                end
            end else if (bus.bit_clk_falling_edge) begin
                case (r_state)
                    DELAY: begin
                        w_state_nxt    = DATA;
                        w_counting_nxt = 1'b1;
                        w_bit_nxt      = BIT_TOP;
                    end
                    DATA: begin
                        if (r_bit_index != '0) begin
                            w_bit_nxt = r_bit_index - 1'b1;
                        end else begin
                            w_word_done_nxt = 1'b1;
                            if (!IS_TDM) begin
                                w_state_nxt      = IDLE;
                                w_counting_nxt   = 1'b0;
                                w_frame_done_nxt = (r_slot_index == SLOT_W'(1));
                            end else if (r_slot_index == SLOT_LAST) begin
                                w_state_nxt      = IDLE;
                                w_counting_nxt   = 1'b0;
                                w_frame_done_nxt = 1'b1;
                            end else if (PAD_FREE) begin
                                w_slot_nxt = r_slot_index + 1'b1;
                                w_bit_nxt  = BIT_TOP;
                            end else begin
                                w_state_nxt    = PAD;
                                w_counting_nxt = 1'b0;
                                w_pad_nxt      = '0;
                            end
                        end
                    end
                    PAD: begin
                        if (r_pad_count == PAD_LAST) begin
                            w_state_nxt    = DATA;
                            w_counting_nxt = 1'b1;
                            w_slot_nxt     = r_slot_index + 1'b1;
                            w_bit_nxt      = BIT_TOP;
                        end else begin
                            w_pad_nxt = r_pad_count + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // A new sync error outranks a simultaneous clear.
            w_error_flag_nxt = w_sync_error_nxt | (r_error_flag & ~bus.clear_error);
        end
    end

    assign bus.counting   = r_counting;
    assign bus.bit_index  = r_bit_index;
    assign bus.slot_index = r_slot_index;
    assign bus.word_done  = r_word_done;
    assign bus.frame_done = r_frame_done;
    assign bus.sync_error = r_sync_error;
    assign bus.error_flag = r_error_flag;

endmodule
